instruction_fetch_ctrl: RTL and testbench
=========================================

INSTRUCTION_FETCH_CTRL -- requirements
Module: instruction_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, meaning the byte-address width of the PC.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, meaning the instruction word width.
REQ-003 The block SHALL have parameter RESET_PC, default 0, meaning the PC value loaded on reset.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, the asynchronous active-high reset.
REQ-006 The block SHALL have port fetch_en, input, 1 bit, which permits new fetches.
REQ-007 The block SHALL have port imem_addr, output, ADDR_WIDTH bits, the byte address to instruction memory.
REQ-008 The block SHALL have port imem_data, input, DATA_WIDTH bits, the combinational read data.
REQ-009 The block SHALL have port imem_unvalid, input, 1 bit, the out-of-range flag from memory.
REQ-010 The block SHALL have port redirect_valid, input, 1 bit, a branch/jump request.
REQ-011 The block SHALL have port redirect_addr, input, ADDR_WIDTH bits, the branch/jump target byte address.
REQ-012 The block SHALL have port instr_valid, output, 1 bit, meaning instr and instr_pc are offered.
REQ-013 The block SHALL have port instr_ready, input, 1 bit, the consumer accept.
REQ-014 The block SHALL have port instr, output, DATA_WIDTH bits, the fetched word.
REQ-015 The block SHALL have port instr_pc, output, ADDR_WIDTH bits, the byte address of instr.
REQ-016 The block SHALL have port fault, output, 1 bit, meaning a fetch fault is latched.
REQ-017 The block SHALL have port fault_addr, output, ADDR_WIDTH bits, the PC that faulted.

Function
REQ-018 imem_addr SHALL equal the internal pc register combinationally.
REQ-019 FSM states SHALL be IDLE, RUN and FAULT; IDLE->RUN when fetch_en=1; RUN->IDLE when fetch_en=0; RUN->FAULT on a fetch with imem_unvalid=1; FAULT->RUN (fetch_en=1) or FAULT->IDLE (fetch_en=0) only on redirect_valid.
REQ-020 A fetch SHALL occur in RUN when the output slot is empty or instr_ready=1: instr<=imem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+2; latency is one cycle from address to valid.
REQ-021 When instr_valid=1 and instr_ready=0, instr, instr_pc and pc SHALL hold.
REQ-022 An accepted instruction with no fetch in the same cycle SHALL clear instr_valid.
REQ-023 The PC increment SHALL be modulo 2^ADDR_WIDTH (0xFFFE -> 0x0000).
REQ-024 redirect_valid SHALL have top priority in every state: pc<=redirect_addr, instr_valid<=0 next cycle, any held instruction discarded, no fetch that cycle.
REQ-025 redirect_valid together with imem_unvalid SHALL NOT raise fault.
REQ-026 An instruction accepted in the same cycle as a redirect SHALL count as consumed.
REQ-027 On a faulting fetch: fault<=1, fault_addr<=pc, instr_valid<=0, pc holds.
REQ-028 fault SHALL clear on the redirect that leaves FAULT.
REQ-029 In IDLE, no fetch SHALL occur; a valid held instruction remains offered until accepted.

Reset
REQ-030 When rst=1 (asynchronous): state=IDLE, pc=RESET_PC, instr_valid=0, instr=0, instr_pc=0, fault=0, fault_addr=0.
REQ-031 Reset asserted mid-stall or mid-fault SHALL abandon all state; the first fetch after release SHALL be at RESET_PC.

Configuration
REQ-032 With FETCH_ALIGN_CHECK_EN defined, a redirect with redirect_addr[0]=1 SHALL enter FAULT with fault_addr=redirect_addr and no fetch; without it, bit 0 SHALL be forced to 0 and the redirect SHALL proceed normally.

Verification
REQ-033 Reset, fetch_en=1, instr_ready=1, memory words 0x300A, 0x3114 -> instr_valid at cycle 2; instr 0x300A/pc 0x0000, then 0x3114/pc 0x0002.
REQ-034 instr_ready=0 for 3 cycles while valid at pc 0x0004 -> instr, instr_pc, imem_addr=0x0006 stable; resumes 0x0006 on ready.
REQ-035 redirect_valid=1, redirect_addr=0x0010 while a stalled instruction is held -> instr_valid=0 next cycle, then instr_pc=0x0010.
REQ-036 Fetch at pc 0x0800 with imem_unvalid=1 -> fault=1, fault_addr=0x0800, instr_valid=0; redirect to 0x0000 clears fault.
REQ-037 pc=0xFFFE fetch with imem_unvalid=0 -> next imem_addr=0x0000; redirect_addr=0x0011 -> fault with FETCH_ALIGN_CHECK_EN, fetch at 0x0010 without it.
REQ-038 rst pulsed mid-stall -> all outputs 0 immediately; the first fetch after release is at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_ctrl.sv
// rtl/instruction_fetch_ctrl.sv - instruction fetch controller (optional FETCH_ALIGN_CHECK_EN)
module instruction_fetch_ctrl #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    input  logic                  imem_unvalid,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  fault,
    output logic [ADDR_WIDTH-1:0] fault_addr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic                    instr_valid_q, instr_valid_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]   instr_pc_q, instr_pc_d;
    logic                    fault_q, fault_d;
    logic [ADDR_WIDTH-1:0]   fault_addr_q, fault_addr_d;

    logic                    accepted;
    logic                    fetch_ok;
    logic                    misaligned;
    logic [ADDR_WIDTH-1:0]   redirect_target;

    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fault       = fault_q;
    assign fault_addr  = fault_addr_q;

    // Next-state logic: redirect wins, then fetch/stall/consume per state
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        instr_valid_d   = instr_valid_q;
        instr_d         = instr_q;
        instr_pc_d      = instr_pc_q;
        fault_d         = fault_q;
        fault_addr_d    = fault_addr_q;

        accepted        = instr_valid_q & instr_ready;
        fetch_ok        = (state_q == RUN) & fetch_en & (~instr_valid_q | instr_ready);
        redirect_target = redirect_addr & ~ADDR_WIDTH'(1);
`ifdef FETCH_ALIGN_CHECK_EN
        misaligned      = redirect_addr[0];
`else
        misaligned      = 1'b0;
`endif

        if (redirect_valid) begin
            // Any held instruction is dropped; nothing is fetched this cycle.
            instr_valid_d = 1'b0;
            if (misaligned) begin
                state_d      = FAULT;
                fault_d      = 1'b1;
                fault_addr_d = redirect_addr;
            end else begin
                pc_d    = redirect_target;
                fault_d = 1'b0;
                state_d = fetch_en ? RUN : IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (accepted) instr_valid_d = 1'b0;
                    if (fetch_en) state_d = RUN;
                end
                RUN: begin
                    if (!fetch_en) begin
                        state_d = IDLE;
                        if (accepted) instr_valid_d = 1'b0;
                    end else if (fetch_ok) begin
                        if (imem_unvalid) begin
                            // pc holds so fault_addr and imem_addr agree.
                            state_d       = FAULT;
                            fault_d       = 1'b1;
                            fault_addr_d  = pc_q;
                            instr_valid_d = 1'b0;
                        end else begin
                            instr_d       = imem_data;
                            instr_pc_d    = pc_q;
                            instr_valid_d = 1'b1;
                            pc_d          = pc_q + ADDR_WIDTH'(2);
                        end
                    end
                end
                FAULT: begin
                    // Only a redirect leaves FAULT.
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            fault_q       <= 1'b0;
            fault_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            fault_q       <= fault_d;
            fault_addr_q  <= fault_addr_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// tb/tb_instruction_fetch_ctrl.sv - self-checking bench for instruction_fetch_ctrl
module tb_instruction_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_unvalid;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        fault;
    logic [15:0] fault_addr;

    logic        bad_en;
    logic [15:0] bad_addr;

    int checks = 0;
    int passes = 0;

    instruction_fetch_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_addr(imem_addr),
        .imem_data(imem_data), .imem_unvalid(imem_unvalid),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .fault(fault), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the byte address
    function automatic logic [15:0] word_at(input logic [15:0] a);
        if (a == 16'h0000) return 16'h300A;
        if (a == 16'h0002) return 16'h3114;
        return a ^ 16'hA5C3;
    endfunction

    assign imem_data    = word_at(imem_addr);
    assign imem_unvalid = bad_en && (imem_addr == bad_addr);

    // Reference model: 0 idle, 1 running, 2 faulted
    int          m_mode;
    logic [15:0] m_pc, m_instr, m_ipc, m_faddr;
    logic        m_valid, m_fault;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_pc = 16'h0000; m_valid = 0; m_instr = 0;
            m_ipc = 0; m_fault = 0; m_faddr = 0;
        end else if (redirect_valid) begin
            m_valid = 0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (redirect_addr[0]) begin
                m_mode = 2; m_fault = 1; m_faddr = redirect_addr;
            end else begin
                m_pc = redirect_addr; m_fault = 0; m_mode = fetch_en ? 1 : 0;
            end
`else
            m_pc = {redirect_addr[15:1], 1'b0};
            m_fault = 0;
            m_mode = fetch_en ? 1 : 0;
`endif
        end else if (m_mode == 0) begin
            if (m_valid && instr_ready) m_valid = 0;
            if (fetch_en) m_mode = 1;
        end else if (m_mode == 1) begin
            if (!fetch_en) begin
                m_mode = 0;
                if (m_valid && instr_ready) m_valid = 0;
            end else if (!m_valid || instr_ready) begin
                if (bad_en && m_pc == bad_addr) begin
                    m_mode = 2; m_fault = 1; m_faddr = m_pc; m_valid = 0;
                end else begin
                    m_instr = word_at(m_pc); m_ipc = m_pc; m_valid = 1;
                    m_pc = 16'((32'(m_pc) + 2) % 65536);
                end
            end
        end
    end

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        checks++;
        if (instr_valid === m_valid && imem_addr === m_pc && fault === m_fault &&
            fault_addr === m_faddr && instr === m_instr && instr_pc === m_ipc)
            passes++;
        else
            $display("FAIL model t=%0t: dut v=%0b a=%h i=%h ipc=%h f=%0b fa=%h required v=%0b a=%h i=%h ipc=%h f=%0b fa=%h",
                     $time, instr_valid, imem_addr, instr, instr_pc, fault, fault_addr,
                     m_valid, m_pc, m_instr, m_ipc, m_fault, m_faddr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1; fetch_en = 0; instr_ready = 0; redirect_valid = 0;
        redirect_addr = 0; bad_en = 0; bad_addr = 0;
        repeat (2) tick();
        chk("reset_valid", {31'd0, instr_valid}, 0);
        chk("reset_addr", {16'd0, imem_addr}, 32'h0000);
        chk("reset_fault", {31'd0, fault}, 0);

        // Streaming fetch from reset
        rst = 0; fetch_en = 1; instr_ready = 1;
        tick();
        chk("cycle1_valid", {31'd0, instr_valid}, 0);
        tick();
        chk("first_instr", {16'd0, instr}, 32'h300A);
        chk("first_pc", {16'd0, instr_pc}, 32'h0000);
        tick();
        chk("second_instr", {16'd0, instr}, 32'h3114);
        chk("second_pc", {16'd0, instr_pc}, 32'h0002);
        tick();
        chk("third_pc", {16'd0, instr_pc}, 32'h0004);

        // Stall three cycles at pc 4
        instr_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", {16'd0, instr_pc}, 32'h0004);
            chk("stall_addr", {16'd0, imem_addr}, 32'h0006);
        end
        instr_ready = 1;
        tick();
        chk("resume_pc", {16'd0, instr_pc}, 32'h0006);

        // Redirect while a stalled instruction is held
        instr_ready = 0;
        tick();
        redirect_valid = 1; redirect_addr = 16'h0010;
        tick();
        redirect_valid = 0;
        chk("redir_valid", {31'd0, instr_valid}, 0);
        instr_ready = 1;
        tick();
        chk("redir_pc", {16'd0, instr_pc}, 32'h0010);

        // Faulting fetch at 0x0800, then redirects clear it
        bad_en = 1; bad_addr = 16'h0800;
        redirect_valid = 1; redirect_addr = 16'h0800;
        tick();
        redirect_valid = 0;
        tick();
        chk("fault_flag", {31'd0, fault}, 1);
        chk("fault_addr", {16'd0, fault_addr}, 32'h0800);
        chk("fault_valid", {31'd0, instr_valid}, 0);
        tick();
        redirect_valid = 1; redirect_addr = 16'h0000;
        tick();
        redirect_valid = 0;
        chk("fault_clear", {31'd0, fault}, 0);

        // Redirect coinciding with an out-of-range fetch must not fault
        bad_addr = 16'h0000;
        redirect_valid = 1; redirect_addr = 16'h0020;
        tick();
        redirect_valid = 0; bad_en = 0;
        chk("redir_unvalid", {31'd0, fault}, 0);

        // PC wrap
        redirect_valid = 1; redirect_addr = 16'hFFFE;
        tick();
        redirect_valid = 0;
        tick();
        chk("wrap_ipc", {16'd0, instr_pc}, 32'hFFFE);
        chk("wrap_addr", {16'd0, imem_addr}, 32'h0000);

        // Odd redirect target
        redirect_valid = 1; redirect_addr = 16'h0011;
        tick();
        redirect_valid = 0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("odd_fault", {31'd0, fault}, 1);
        chk("odd_faddr", {16'd0, fault_addr}, 32'h0011);
        redirect_valid = 1; redirect_addr = 16'h0010;
        tick();
        redirect_valid = 0;
`else
        chk("odd_addr", {16'd0, imem_addr}, 32'h0010);
`endif
        tick();
        chk("odd_ipc", {16'd0, instr_pc}, 32'h0010);

        // IDLE keeps a held instruction offered until accepted
        instr_ready = 0;
        tick();
        fetch_en = 0;
        tick();
        chk("idle_hold", {31'd0, instr_valid}, 1);
        instr_ready = 1;
        tick();
        chk("idle_drain", {31'd0, instr_valid}, 0);

        // Ready toggling pattern
        fetch_en = 1;
        for (int i = 0; i < 16; i++) begin
            instr_ready = ((16'b1011_0010_1110_0101 >> i) & 16'd1) != 0;
            tick();
        end

        // Reset mid-stall
        instr_ready = 0;
        tick();
        #2 rst = 1;
        #1;
        chk("rst_async_valid", {31'd0, instr_valid}, 0);
        chk("rst_async_instr", {16'd0, instr}, 0);
        chk("rst_async_ipc", {16'd0, instr_pc}, 0);
        chk("rst_async_addr", {16'd0, imem_addr}, 32'h0000);
        @(negedge clk);
        rst = 0; instr_ready = 1;
        tick();
        tick();
        chk("post_rst_pc", {16'd0, instr_pc}, 32'h0000);
        chk("post_rst_instr", {16'd0, instr}, 32'h300A);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
